// File: rtl/control_unit.sv
// ProjectB control unit: Moore FSM sequencing fetch/decode/execute.
// Decodes the instruction held in IR into register-file, ALU and data-memory
// controls. All outputs are registered alongside the state register, so each
// output reflects the state it is presented with.
// Ports:
//   clk, reset       system clock; synchronous active-high reset to INIT
//   IR               current instruction (op = IR[15:12])
//   PC_clr, PC_up    program-counter clear / increment
//   IR_ld            load IR from instruction memory
//   D_addr, D_wr     data-memory address / write enable
//   RF_s             RF write-data select (1 = memory, 0 = ALU)
//   RF_W_addr/_en    RF write port
//   RF_Ra_addr/Rb    RF read addresses
//   ALU_s0           ALU select (0 pass A, 1 A+B, 2 A-B)
//   state            current state code
module control_unit #(
    parameter int unsigned RF_AW  = 4,
    parameter int unsigned D_AW   = 8,
    parameter int unsigned ALU_SW = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       IR,
    output logic              PC_clr,
    output logic              PC_up,
    output logic              IR_ld,
    output logic [D_AW-1:0]   D_addr,
    output logic              D_wr,
    output logic              RF_s,
    output logic [RF_AW-1:0]  RF_W_addr,
    output logic              RF_W_en,
    output logic [RF_AW-1:0]  RF_Ra_addr,
    output logic [RF_AW-1:0]  RF_Rb_addr,
    output logic [ALU_SW-1:0] ALU_s0,
    output logic [3:0]        state
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    localparam logic [3:0] OP_STORE = 4'd1;
    localparam logic [3:0] OP_LOAD  = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_HALT  = 4'd5;

    state_t st;
    state_t nxt;

    assign state = st;

    // Next-state selection; unused codes fall back to INIT.
    always_comb begin
        nxt = S_INIT;
        case (st)
            S_INIT:   nxt = S_FETCH;
            S_FETCH:  nxt = S_DECODE;
            S_DECODE: begin
                case (IR[15:12])
                    OP_STORE: nxt = S_STORE;
                    OP_LOAD:  nxt = S_LOAD_A;
                    OP_ADD:   nxt = S_ADD;
                    OP_SUB:   nxt = S_SUB;
                    OP_HALT:  nxt = S_HALT;
                    default:  nxt = S_NOOP;
                endcase
            end
            S_NOOP:   nxt = S_FETCH;
            S_LOAD_A: nxt = S_LOAD_B;
            S_LOAD_B: nxt = S_FETCH;
            S_STORE:  nxt = S_FETCH;
            S_ADD:    nxt = S_FETCH;
            S_SUB:    nxt = S_FETCH;
            S_HALT:   nxt = S_HALT;
            default:  nxt = S_INIT;
        endcase
    end

    // State and registered Moore outputs, decoded from the state being entered.
    always_ff @(posedge clk) begin
        PC_clr     <= 1'b0;
        PC_up      <= 1'b0;
        IR_ld      <= 1'b0;
        D_addr     <= '0;
        D_wr       <= 1'b0;
        RF_s       <= 1'b0;
        RF_W_addr  <= '0;
        RF_W_en    <= 1'b0;
        RF_Ra_addr <= '0;
        RF_Rb_addr <= '0;
        ALU_s0     <= '0;
        if (reset) begin
            st     <= S_INIT;
            PC_clr <= 1'b1;
        end else begin
            st <= nxt;
            case (nxt)
                S_INIT:   PC_clr <= 1'b1;
                S_FETCH: begin
                    IR_ld <= 1'b1;
                    PC_up <= 1'b1;
                end
                S_LOAD_A: begin
                    D_addr <= D_AW'(IR[7:0]);
                    RF_s   <= 1'b1;
                end
                S_LOAD_B: begin
                    D_addr    <= D_AW'(IR[7:0]);
                    RF_s      <= 1'b1;
                    RF_W_addr <= RF_AW'(IR[11:8]);
                    RF_W_en   <= 1'b1;
                end
                S_STORE: begin
                    D_addr     <= D_AW'(IR[7:0]);
                    RF_Ra_addr <= RF_AW'(IR[11:8]);
                    D_wr       <= 1'b1;
                end
                S_ADD, S_SUB: begin
                    RF_Ra_addr <= RF_AW'(IR[11:8]);
                    RF_Rb_addr <= RF_AW'(IR[7:4]);
                    RF_W_addr  <= RF_AW'(IR[3:0]);
                    RF_W_en    <= 1'b1;
                    ALU_s0     <= (nxt == S_ADD) ? ALU_SW'(1) : ALU_SW'(2);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: the driver expands each instruction into
// its expected per-cycle output records and queues them; the monitor pops one
// record per cycle and compares it against the DUT outputs.
module tb_control_unit;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_clr;
        logic       pc_up;
        logic       ir_ld;
        logic [7:0] d_addr;
        logic       d_wr;
        logic       rf_s;
        logic [3:0] w_addr;
        logic       w_en;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [2:0] alu;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] IR = 16'h0000;
    logic        PC_clr, PC_up, IR_ld, D_wr, RF_s, RF_W_en;
    logic [7:0]  D_addr;
    logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, state;
    logic [2:0]  ALU_s0;

    control_unit #(.RF_AW(4), .D_AW(8), .ALU_SW(3)) dut (
        .clk(clk), .reset(reset), .IR(IR),
        .PC_clr(PC_clr), .PC_up(PC_up), .IR_ld(IR_ld),
        .D_addr(D_addr), .D_wr(D_wr), .RF_s(RF_s),
        .RF_W_addr(RF_W_addr), .RF_W_en(RF_W_en),
        .RF_Ra_addr(RF_Ra_addr), .RF_Rb_addr(RF_Rb_addr),
        .ALU_s0(ALU_s0), .state(state)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   failures = 0;
    rec_t exp_q[$];
    rec_t plan[$];
    rec_t act;

    assign act = '{st: state, pc_clr: PC_clr, pc_up: PC_up, ir_ld: IR_ld,
                   d_addr: D_addr, d_wr: D_wr, rf_s: RF_s, w_addr: RF_W_addr,
                   w_en: RF_W_en, ra: RF_Ra_addr, rb: RF_Rb_addr, alu: ALU_s0};

    function automatic rec_t blank(input logic [3:0] s);
        rec_t r;
        r = '0;
        r.st = s;
        return r;
    endfunction

    // Reference model: cycle-by-cycle outputs of one instruction, fetch included.
    task automatic build(input logic [15:0] ir);
        rec_t r;
        plan = {};
        r = blank(4'd1); r.pc_up = 1'b1; r.ir_ld = 1'b1; plan.push_back(r);
        plan.push_back(blank(4'd2));
        case (ir[15:12])
            4'd1: begin
                r = blank(4'd6); r.d_addr = ir[7:0]; r.ra = ir[11:8]; r.d_wr = 1'b1;
                plan.push_back(r);
            end
            4'd2: begin
                r = blank(4'd4); r.d_addr = ir[7:0]; r.rf_s = 1'b1;
                plan.push_back(r);
                r.st = 4'd5; r.w_addr = ir[11:8]; r.w_en = 1'b1;
                plan.push_back(r);
            end
            4'd3, 4'd4: begin
                r = blank(ir[15:12] == 4'd3 ? 4'd7 : 4'd8);
                r.ra = ir[11:8]; r.rb = ir[7:4]; r.w_addr = ir[3:0]; r.w_en = 1'b1;
                r.alu = (ir[15:12] == 4'd3) ? 3'd1 : 3'd2;
                plan.push_back(r);
            end
            4'd5: plan.push_back(blank(4'd9));
            default: plan.push_back(blank(4'd3));
        endcase
    endtask

    task automatic tick(input rec_t e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rec_t r;
        r = blank(4'd0);
        r.pc_clr = 1'b1;
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) tick(r);
        reset = 1'b0;
    endtask

    // cut > 0: assert reset after that many cycles of the instruction.
    task automatic run(input logic [15:0] ir, input int cut, input int halt_hold);
        int n;
        IR = ir;
        build(ir);
        n = (cut > 0 && cut < plan.size()) ? cut : plan.size();
        for (int i = 0; i < n; i++) tick(plan[i]);
        if (ir[15:12] == 4'd5 && n == plan.size())
            for (int i = 0; i < halt_hold; i++) tick(plan[plan.size()-1]);
        if (cut > 0 || ir[15:12] == 4'd5) do_reset(1);
    endtask

    // Monitor: one expected record per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            rec_t e;
            e = exp_q.pop_front();
            checks++;
            if (act !== e) begin
                failures++;
                $display("FAIL outputs state act=%0d req=%0d vec act=%h req=%h",
                         act.st, e.st, act, e);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int op;
        int cut;
        logic [15:0] ir;
        do_reset(1);
        run(16'h2A1B, 0, 0);
        run(16'h1305, 0, 0);
        run(16'h1305, 0, 0);
        run(16'h3124, 0, 0);
        run(16'h4124, 0, 0);
        run(16'h0000, 0, 0);
        run(16'h5000, 0, 20);
        run(16'h2A1B, 3, 0);
        run(16'h7FFF, 0, 0);
        do_reset(4);
        run(16'hF123, 0, 0);
        for (int k = 0; k < 300; k++) begin
            op = $urandom_range(0, 15);
            ir = 16'($urandom());
            ir[15:12] = 4'(op);
            cut = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 4) : 0;
            run(ir, cut, $urandom_range(0, 6));
        end
        run(16'h5ABC, 0, 5);
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain act=%0d req=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
